me_mv_writer: RTL and testbench

ME_MV_WRITER -- requirements
Module: me_mv_writer

---
 rtl/me_pkg.sv | 36 +++
 rtl/me_mv_writer_fifo.sv | 54 +++++
 rtl/me_mv_writer.sv | 138 +++++++++++++
 tb/tb_me_mv_writer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants for the motion-vector writer: MV word layout, bias and table stride.
// Also holds the FIFO entry type and the word packing helper.
package me_pkg;

    localparam int MV_SAD_LSB = 0;
    localparam int MV_SAD_W   = 14;
    localparam int MV_X_LSB   = 14;
    localparam int MV_Y_LSB   = 19;
    localparam int MV_BLK_LSB = 24;
    localparam int MV_COMP_W  = 5;
    localparam int MV_BLK_W   = 8;

    localparam logic [MV_COMP_W-1:0] MV_BIAS     = 5'd16;
    localparam logic [31:0]          ADDR_STRIDE = 32'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } mv_entry_t;

    function automatic logic [31:0] pack_mv_word(
        input logic [MV_BLK_W-1:0]  blk,
        input logic [MV_COMP_W-1:0] mv_y,
        input logic [MV_COMP_W-1:0] mv_x,
        input logic [MV_SAD_W-1:0]  sad
    );
        logic [31:0] w;
        w = '0;
        w[MV_BLK_LSB +: MV_BLK_W]  = blk;
        w[MV_Y_LSB   +: MV_COMP_W] = mv_y;
        w[MV_X_LSB   +: MV_COMP_W] = mv_x;
        w[MV_SAD_LSB +: MV_SAD_W]  = sad;
        return w;
    endfunction

endpackage

// File: rtl/me_mv_writer_fifo.sv
// Synchronous result queue; a push into a full queue is accepted when a pop happens in
// the same cycle. The head entry is read straight from the storage registers.
module mv_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage is reset too because its head drives the output bus directly;
    // at this depth the cost is a handful of flops, larger queues would gate the output instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/me_mv_writer.sv
// Captures one motion-estimation result per data_valid rise, packs it into an MV table
// word, queues it for the store port and accumulates per-frame SAD totals.
module me_mv_writer
    import me_pkg::*;
#(
    parameter int          SAD_BIT_WIDTH    = 14,
    parameter int          FIFO_DEPTH       = 4,
    parameter int          BLOCKS_PER_FRAME = 396,
    parameter logic [31:0] MV_BASE_ADDR     = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SAD_BIT_WIDTH-1:0] MSAD,
    input  logic [4:0]               MSAD_column,
    input  logic [4:0]               MSAD_row,
    input  logic                     data_valid,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [31:0]              wr_addr,
    output logic [31:0]              wr_data,
    output logic                     frame_done,
    output logic [31:0]              frame_sad,
    output logic                     overflow
);

    logic                     data_valid_q;
    logic                     armed;
    logic                     capture;
    logic                     cap_valid;
    logic [SAD_BIT_WIDTH-1:0] cap_msad;
    logic [MV_COMP_W-1:0]     cap_mv_x;
    logic [MV_COMP_W-1:0]     cap_mv_y;
    logic [MV_SAD_W-1:0]      msad_field;
    logic [31:0]              msad_acc;
    logic [15:0]              blk_idx;
    logic [31:0]              acc;
    logic                     pop;
    logic                     accept;
    logic                     drop;
    logic                     head_is_last;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    mv_entry_t                push_entry;
    mv_entry_t                head_entry;

    // armed stays low for the first edge after reset so a level already high is not a rise
    assign capture = data_valid & ~data_valid_q & armed;

    // NOTE: every register below uses non-blocking assignment so all stages update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_valid_q <= 1'b0;
            armed        <= 1'b0;
            cap_valid    <= 1'b0;
            cap_msad     <= '0;
            cap_mv_x     <= '0;
            cap_mv_y     <= '0;
        end else begin
            armed        <= 1'b1;
            data_valid_q <= data_valid;
            cap_valid    <= capture;
            if (capture) begin
                cap_msad <= MSAD;
                cap_mv_x <= MSAD_column - MV_BIAS;
                cap_mv_y <= MSAD_row - MV_BIAS;
            end
        end
    end

    generate
        if (SAD_BIT_WIDTH >= MV_SAD_W) begin : g_sad_trunc
            assign msad_field = cap_msad[MV_SAD_W-1:0];
        end else begin : g_sad_ext
            assign msad_field = {{(MV_SAD_W - SAD_BIT_WIDTH){1'b0}}, cap_msad};
        end
    endgenerate

    assign msad_acc = 32'(cap_msad);

    // NOTE: each output of this block is assigned on every path before any condition,
    // which keeps the logic purely combinational with no inferred storage.
    always_comb begin
        push_entry.addr = MV_BASE_ADDR + ADDR_STRIDE * {16'd0, blk_idx};
        push_entry.data = pack_mv_word(blk_idx[MV_BLK_W-1:0], cap_mv_y, cap_mv_x, msad_field);
    end

    assign wr_valid = (fifo_count != '0);
    assign pop      = wr_ready & ~fifo_empty;
    assign accept   = cap_valid & (~fifo_full | pop);
    assign drop     = cap_valid & fifo_full & ~pop;
    assign wr_addr  = head_entry.addr;
    assign wr_data  = head_entry.data;

    // The block index is recovered from the address so it is exact beyond the 8-bit field
    assign head_is_last = ((head_entry.addr - MV_BASE_ADDR) ==
                           ADDR_STRIDE * 32'(BLOCKS_PER_FRAME - 1));

    mv_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_idx    <= '0;
            acc        <= '0;
            frame_sad  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                blk_idx <= (blk_idx == 16'(BLOCKS_PER_FRAME - 1)) ? 16'd0 : blk_idx + 16'd1;
            end
            if (drop) overflow <= 1'b1;
            frame_done <= pop & head_is_last;
            // A push in the frame-end cycle belongs to the next frame's total
            if (pop && head_is_last) begin
                frame_sad <= acc;
                acc       <= accept ? msad_acc : 32'd0;
            end else if (accept) begin
                acc <= acc + msad_acc;
            end
        end
    end

endmodule

// File: tb/tb_me_mv_writer.sv
// Directed bench for me_mv_writer: one instance with defaults, one with a 3-block frame.
module tb_me_mv_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] MSAD = '0;
    logic [4:0]  col = '0;
    logic [4:0]  row = '0;
    logic        data_valid = 1'b0;
    logic        wr_ready = 1'b0;

    logic        wr_valid, frame_done, overflow;
    logic [31:0] wr_addr, wr_data, frame_sad;
    logic        wr_valid_3, frame_done_3, overflow_3;
    logic [31:0] wr_addr_3, wr_data_3, frame_sad_3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    me_mv_writer dut (
        .clk (clk), .rst (rst), .MSAD (MSAD), .MSAD_column (col), .MSAD_row (row),
        .data_valid (data_valid), .wr_valid (wr_valid), .wr_ready (wr_ready),
        .wr_addr (wr_addr), .wr_data (wr_data), .frame_done (frame_done),
        .frame_sad (frame_sad), .overflow (overflow)
    );

    me_mv_writer #(.BLOCKS_PER_FRAME(3)) dut3 (
        .clk (clk), .rst (rst), .MSAD (MSAD), .MSAD_column (col), .MSAD_row (row),
        .data_valid (data_valid), .wr_valid (wr_valid_3), .wr_ready (wr_ready),
        .wr_addr (wr_addr_3), .wr_data (wr_data_3), .frame_done (frame_done_3),
        .frame_sad (frame_sad_3), .overflow (overflow_3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; data_valid = 1'b0; wr_ready = 1'b0; MSAD = '0; col = '0; row = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // Rise on data_valid for one cycle; wr_ready is set per edge (capture edge, push edge)
    task automatic pulse(input logic [13:0] s, input logic [4:0] c, input logic [4:0] r,
                         input logic rdy_a, input logic rdy_b);
        MSAD = s; col = c; row = r; data_valid = 1'b1; wr_ready = rdy_a;
        tick();
        data_valid = 1'b0; wr_ready = rdy_b;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; #2; rst = 1'b0; #1;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b exp 0", wr_valid); end
        checks++; if (wr_addr !== 32'h0) begin errors++; $display("FAIL reset_wr_addr: got %h exp 0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h exp 0", wr_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b exp 0", frame_done); end
        checks++; if (frame_sad !== 32'h0) begin errors++; $display("FAIL reset_frame_sad: got %h exp 0", frame_sad); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
        do_reset();
    endtask

    task automatic test_latency();
        do_reset();
        MSAD = 14'd100; col = 5'd16; row = 5'd16; wr_ready = 1'b1; data_valid = 1'b1;
        tick();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1_valid: got %b exp 0", wr_valid); end
        tick();
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL lat_cycle2_valid: got %b exp 1", wr_valid); end
        checks++; if (wr_addr !== 32'h0) begin errors++; $display("FAIL lat_addr: got %h exp 0", wr_addr); end
        checks++; if (wr_data !== 32'h0000_0064) begin errors++; $display("FAIL lat_data: got %h exp 00000064", wr_data); end
        tick();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL lat_popped: got %b exp 0", wr_valid); end
        data_valid = 1'b0;
        tick();
    endtask

    task automatic test_mv_pack();
        do_reset();
        for (int i = 0; i < 3; i++) pulse(14'd1, 5'd16, 5'd16, 1'b1, 1'b1);
        pulse(14'd5, 5'd0, 5'd31, 1'b1, 1'b1);
        checks++; if (wr_addr !== 32'h0000_000C) begin errors++; $display("FAIL pack_addr_blk3: got %h exp 0000000c", wr_addr); end
        checks++; if (wr_data !== 32'h037C_0005) begin errors++; $display("FAIL pack_data_blk3: got %h exp 037c0005", wr_data); end
        checks++; if (wr_addr_3 !== 32'h0) begin errors++; $display("FAIL pack_wrap_addr: got %h exp 0", wr_addr_3); end
        checks++; if (wr_data_3 !== 32'h007C_0005) begin errors++; $display("FAIL pack_wrap_data: got %h exp 007c0005", wr_data_3); end
        pulse(14'h3FFF, 5'd31, 5'd0, 1'b1, 1'b1);
        checks++; if (wr_addr !== 32'h0000_0010) begin errors++; $display("FAIL pack_addr_blk4: got %h exp 00000010", wr_addr); end
        checks++; if (wr_data !== 32'h0483_FFFF) begin errors++; $display("FAIL pack_data_blk4: got %h exp 0483ffff", wr_data); end
        tick();
    endtask

    task automatic test_held_high();
        int n;
        do_reset();
        n = 0;
        MSAD = 14'd9; col = 5'd16; row = 5'd16; wr_ready = 1'b1; data_valid = 1'b1;
        repeat (20) begin tick(); if (wr_valid) n++; end
        data_valid = 1'b0;
        repeat (5) begin tick(); if (wr_valid) n++; end
        checks++; if (n !== 1) begin errors++; $display("FAIL held_high_words: got %0d exp 1", n); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse(14'(i + 1), 5'd16, 5'd16, 1'b0, 1'b0);
            if (i == 3) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_after4: got %b exp 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_after5: got %b exp 1", overflow); end
        tick();
        checks++; if (wr_valid !== 1'b1 || wr_data[31:24] !== 8'd0) begin errors++; $display("FAIL ovf_stall_hold: got v=%b blk=%0d exp v=1 blk=0", wr_valid, wr_data[31:24]); end
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_valid !== 1'b1 || wr_data[31:24] !== 8'(i) || wr_addr !== 32'(4 * i))
            begin errors++; $display("FAIL ovf_drain_%0d: got v=%b blk=%0d addr=%h exp v=1 blk=%0d", i, wr_valid, wr_data[31:24], wr_addr, i); end
            tick();
        end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b exp 0", wr_valid); end
        pulse(14'd1, 5'd16, 5'd16, 1'b1, 1'b1);
        checks++; if (wr_data[31:24] !== 8'd4) begin errors++; $display("FAIL ovf_next_blk: got %0d exp 4", wr_data[31:24]); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
        tick();
    endtask

    task automatic test_frame();
        do_reset();
        pulse(14'd10, 5'd16, 5'd16, 1'b0, 1'b0);
        pulse(14'd20, 5'd16, 5'd16, 1'b0, 1'b0);
        pulse(14'd30, 5'd16, 5'd16, 1'b0, 1'b0);
        wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (frame_done_3 !== (k == 2)) begin errors++; $display("FAIL frame_done_k%0d: got %b exp %b", k, frame_done_3, k == 2); end
            if (k >= 2) begin
                checks++; if (frame_sad_3 !== 32'd60) begin errors++; $display("FAIL frame_sad_k%0d: got %0d exp 60", k, frame_sad_3); end
            end
        end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_default_done: got %b exp 0", frame_done); end
        pulse(14'd7, 5'd16, 5'd16, 1'b1, 1'b1);
        checks++; if (wr_addr_3 !== 32'h0 || wr_data_3 !== 32'h0000_0007) begin errors++; $display("FAIL frame_next_start: got addr=%h data=%h exp 0/00000007", wr_addr_3, wr_data_3); end
        checks++; if (wr_data !== 32'h0300_0007) begin errors++; $display("FAIL frame_default_blk3: got %h exp 03000007", wr_data); end
        tick();
    endtask

    task automatic test_frame_overlap();
        do_reset();
        pulse(14'd10, 5'd16, 5'd16, 1'b1, 1'b1);
        pulse(14'd20, 5'd16, 5'd16, 1'b1, 1'b1);
        pulse(14'd30, 5'd16, 5'd16, 1'b1, 1'b0);
        pulse(14'd7,  5'd16, 5'd16, 1'b0, 1'b1);
        checks++; if (frame_done_3 !== 1'b1 || frame_sad_3 !== 32'd60) begin errors++; $display("FAIL overlap_end: got done=%b sad=%0d exp 1/60", frame_done_3, frame_sad_3); end
        checks++; if (wr_valid_3 !== 1'b1 || wr_addr_3 !== 32'h0) begin errors++; $display("FAIL overlap_head: got v=%b addr=%h exp 1/0", wr_valid_3, wr_addr_3); end
        pulse(14'd8, 5'd16, 5'd16, 1'b1, 1'b1);
        checks++; if (frame_done_3 !== 1'b0) begin errors++; $display("FAIL overlap_pulse_len: got %b exp 0", frame_done_3); end
        pulse(14'd9, 5'd16, 5'd16, 1'b1, 1'b1);
        tick();
        checks++; if (frame_done_3 !== 1'b1 || frame_sad_3 !== 32'd24) begin errors++; $display("FAIL overlap_next_frame: got done=%b sad=%0d exp 1/24", frame_done_3, frame_sad_3); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(14'd10, 5'd16, 5'd16, 1'b0, 1'b0);
        pulse(14'd20, 5'd16, 5'd16, 1'b0, 1'b0);
        checks++; if (wr_valid_3 !== 1'b1) begin errors++; $display("FAIL rstmid_queued: got %b exp 1", wr_valid_3); end
        #2; rst = 1'b0; #1;
        checks++; if (wr_valid !== 1'b0 || wr_valid_3 !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b/%b exp 0/0", wr_valid, wr_valid_3); end
        tick();
        rst = 1'b1;
        tick();
        pulse(14'd1, 5'd16, 5'd16, 1'b0, 1'b0);
        checks++; if (wr_addr_3 !== 32'h0 || wr_data_3[31:24] !== 8'd0) begin errors++; $display("FAIL rstmid_blk0: got addr=%h blk=%0d exp 0/0", wr_addr_3, wr_data_3[31:24]); end
        checks++; if (frame_sad_3 !== 32'd0) begin errors++; $display("FAIL rstmid_frame_sad: got %0d exp 0", frame_sad_3); end
        pulse(14'd2, 5'd16, 5'd16, 1'b0, 1'b0);
        pulse(14'd3, 5'd16, 5'd16, 1'b0, 1'b0);
        wr_ready = 1'b1;
        repeat (3) tick();
        checks++; if (frame_done_3 !== 1'b1 || frame_sad_3 !== 32'd6) begin errors++; $display("FAIL rstmid_sum: got done=%b sad=%0d exp 1/6", frame_done_3, frame_sad_3); end
        tick();
    endtask

    task automatic test_release_high();
        rst = 1'b0; wr_ready = 1'b0; data_valid = 1'b1; MSAD = 14'd50; col = 5'd16; row = 5'd16;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL release_high_nocap: got %b exp 0", wr_valid); end
        data_valid = 1'b0;
        tick();
        pulse(14'd50, 5'd16, 5'd16, 1'b0, 1'b0);
        checks++; if (wr_valid !== 1'b1 || wr_data !== 32'h0000_0032) begin errors++; $display("FAIL release_high_first: got v=%b data=%h exp 1/00000032", wr_valid, wr_data); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_mv_pack();
        test_held_high();
        test_overflow();
        test_frame();
        test_frame_overlap();
        test_reset_mid();
        test_release_high();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
